// File: rtl/host_csr_slave_if.sv
// Host command bus between the host bus master and the CSR slave.
// Carries command fields toward the slave and read returns back to the master.
interface host_csr_slave_if;
   logic        cmd_vld;
   logic [31:0] addr;
   logic        rw;
   logic [31:0] data_w;
   logic [31:0] data_r;
   logic        rd_vld;

   modport master (
      output cmd_vld, addr, rw, data_w,
      input  data_r, rd_vld
   );

   modport slave (
      input  cmd_vld, addr, rw, data_w,
      output data_r, rd_vld
   );
endinterface

// File: rtl/host_csr_slave.sv
// CSR bank slave on the host command bus with a fixed-latency read return pipeline.
// Optional macro HOST_CSR_SLAVE_ERR_CNT_EN enables the access-error counter and its CSR.
module host_csr_slave #(
   parameter int unsigned NUM_REGS   = 16,
   parameter logic [31:0] ADDR_BASE  = 32'h0000_1000,
   parameter int unsigned RD_LATENCY = 2,
   parameter logic [31:0] ID_VALUE   = 32'h5AB0_0001
) (
   input  logic                   clk,
   input  logic                   reset,
   host_csr_slave_if.slave        bus,
   input  logic [31:0]            sts_in,
   output logic [NUM_REGS*32-1:0] csr_q,
   output logic [15:0]            err_cnt
);

   localparam int unsigned IDX_W = $clog2(NUM_REGS);
   localparam int unsigned LAST  = RD_LATENCY - 1;

   logic [31:0]       off_c;
   logic [29:0]       idx_c;
   logic [IDX_W-1:0]  ridx_c;
   logic              aligned_c;
   logic              legal_c;
   logic              rd_go_c;
   logic [31:0]       rd_data_c;

   logic [31:0]       regs [NUM_REGS];
   logic [LAST:0]     pipe_vld;
   logic [31:0]       pipe_data [RD_LATENCY];

   // Address decode; the modulo subtraction wraps low addresses to a huge index
   assign off_c     = bus.addr - ADDR_BASE;
   assign idx_c     = off_c[31:2];
   assign ridx_c    = idx_c[IDX_W-1:0];
   assign aligned_c = (off_c[1:0] == 2'b00);
   assign legal_c   = aligned_c && (idx_c < 30'(NUM_REGS));
   assign rd_go_c   = bus.cmd_vld && !bus.rw;

`ifdef HOST_CSR_SLAVE_ERR_CNT_EN
   logic        err_hit_c;
   logic        err_c;
   logic [15:0] err_q;

   assign err_hit_c = aligned_c && (idx_c == 30'(NUM_REGS));
   assign err_c     = bus.cmd_vld && !legal_c && !err_hit_c;

   // Saturating error counter, cleared by a write to its own CSR
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         err_q <= 16'h0;
      end else if (bus.cmd_vld && bus.rw && err_hit_c) begin
         err_q <= 16'h0;
      end else if (err_c && (err_q != 16'hFFFF)) begin
         err_q <= err_q + 16'd1;
      end
   end

   assign err_cnt = err_q;
`else
   assign err_cnt = 16'h0;
`endif

   // Read data selected at the sample edge
   always_comb begin
      rd_data_c = 32'hDEAD_BEEF;
      if (legal_c) begin
         if (idx_c == 30'd0) begin
            rd_data_c = ID_VALUE;
         end else if (idx_c == 30'd1) begin
            rd_data_c = sts_in;
         end else begin
            rd_data_c = regs[ridx_c];
         end
      end
`ifdef HOST_CSR_SLAVE_ERR_CNT_EN
      else if (err_hit_c) begin
         rd_data_c = {16'h0, err_q};
      end
`endif
   end

   // CSR storage; slots 0 and 1 mirror the ID constant and the status input
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         for (int unsigned i = 0; i < NUM_REGS; i++) begin
            regs[i] <= (i == 0) ? ID_VALUE : 32'h0;
         end
      end else begin
         regs[1] <= sts_in;
         if (bus.cmd_vld && bus.rw && legal_c && (idx_c >= 30'd2)) begin
            regs[ridx_c] <= bus.data_w;
         end
      end
   end

   always_comb begin
      csr_q = '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
         csr_q[32*i +: 32] = regs[i];
      end
   end

   // Read return shift pipeline; empty slots carry zero data
   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         pipe_vld <= '0;
         for (int unsigned i = 0; i < RD_LATENCY; i++) begin
            pipe_data[i] <= 32'h0;
         end
      end else begin
         for (int unsigned i = LAST; i > 0; i--) begin
            pipe_vld[i]  <= pipe_vld[i-1];
            pipe_data[i] <= pipe_data[i-1];
         end
         pipe_vld[0]  <= rd_go_c;
         pipe_data[0] <= rd_go_c ? rd_data_c : 32'h0;
      end
   end

   assign bus.rd_vld = pipe_vld[LAST];
   assign bus.data_r = pipe_data[LAST];

endmodule

// File: tb/tb_host_csr_slave.sv
// Randomized self-checking bench for host_csr_slave against a queue-based reference model.
// Honours HOST_CSR_SLAVE_ERR_CNT_EN the same way the design does.
module tb_host_csr_slave;

   localparam int unsigned NUM_REGS   = 16;
   localparam int unsigned RD_LATENCY = 2;
   localparam logic [31:0] ADDR_BASE  = 32'h0000_1000;
   localparam logic [31:0] ID_VALUE   = 32'h5AB0_0001;
   localparam int unsigned CW         = NUM_REGS * 32;

   logic          clk = 1'b0;
   logic          rst_n = 1'b0;
   logic [31:0]   sts_in = 32'h0;
   logic [CW-1:0] csr_q;
   logic [15:0]   err_cnt;

   host_csr_slave_if bus ();

   host_csr_slave #(
      .NUM_REGS   (NUM_REGS),
      .ADDR_BASE  (ADDR_BASE),
      .RD_LATENCY (RD_LATENCY),
      .ID_VALUE   (ID_VALUE)
   ) dut (
      .clk     (clk),
      .reset   (rst_n),
      .bus     (bus),
      .sts_in  (sts_in),
      .csr_q   (csr_q),
      .err_cnt (err_cnt)
   );

   always #5 clk = ~clk;

   int          n_cmp = 0;
   int          n_mis = 0;
   int unsigned ec = 0;

   // Reference state: CSR contents, error count, and reads still owed by cycle number
   logic [31:0] m_regs [NUM_REGS];
   int unsigned m_err;
   typedef struct { int unsigned due; logic [31:0] data; } exp_t;
   exp_t expq[$];

   task automatic chk(input string tag, input logic [CW-1:0] got, input logic [CW-1:0] exp);
      n_cmp++;
      if (got !== exp) begin
         n_mis++;
         $display("FAIL %s: got %0h expected %0h (cycle %0d)", tag, got, exp, ec);
      end
   endtask

   function automatic bit m_legal(input logic [31:0] a);
      logic [31:0] off;
      off = a - ADDR_BASE;
      return (off % 4 == 0) && ((off / 4) < NUM_REGS);
   endfunction

   function automatic bit m_is_errcsr(input logic [31:0] a);
`ifdef HOST_CSR_SLAVE_ERR_CNT_EN
      return (a - ADDR_BASE) == 32'(4 * NUM_REGS);
`else
      return (a != a);
`endif
   endfunction

   function automatic logic [31:0] m_read(input logic [31:0] a, input logic [31:0] sts);
      int unsigned idx;
      idx = (a - ADDR_BASE) / 4;
      if (m_legal(a)) begin
         if (idx == 0) return ID_VALUE;
         if (idx == 1) return sts;
         return m_regs[idx];
      end
      if (m_is_errcsr(a)) return {16'h0, 16'(m_err)};
      return 32'hDEAD_BEEF;
   endfunction

   task automatic model_apply();
      int unsigned idx;
      exp_t e;
      if (!bus.cmd_vld) return;
      idx = (bus.addr - ADDR_BASE) / 4;
      if (!bus.rw) begin
         e.due  = ec + RD_LATENCY - 1;
         e.data = m_read(bus.addr, sts_in);
         expq.push_back(e);
      end else if (m_legal(bus.addr) && idx >= 2) begin
         m_regs[idx] = bus.data_w;
      end else if (m_is_errcsr(bus.addr)) begin
         m_err = 0;
      end
      if (!m_legal(bus.addr) && !m_is_errcsr(bus.addr) && m_err < 65535) m_err++;
   endtask

   task automatic check_outputs();
      logic [CW-1:0] e_csr;
      logic [CW-1:0] g_csr;
      if (expq.size() > 0 && expq[0].due == ec) begin
         chk("rd_vld", CW'(bus.rd_vld), CW'(1'b1));
         chk("data_r", CW'(bus.data_r), CW'(expq[0].data));
         void'(expq.pop_front());
      end else begin
         chk("rd_vld_idle", CW'(bus.rd_vld), CW'(1'b0));
         chk("data_r_idle", CW'(bus.data_r), CW'(32'h0));
      end
      e_csr = '0;
      for (int i = 2; i < NUM_REGS; i++) e_csr[32*i +: 32] = m_regs[i];
      g_csr = csr_q;
      g_csr[63:0] = 64'h0;
      chk("csr_q", g_csr, e_csr);
`ifdef HOST_CSR_SLAVE_ERR_CNT_EN
      chk("err_cnt", CW'(err_cnt), CW'(m_err));
`else
      chk("err_cnt", CW'(err_cnt), CW'(16'h0));
`endif
   endtask

   task automatic step();
      @(posedge clk);
      ec++;
      if (rst_n) model_apply();
      #1;
      check_outputs();
   endtask

   task automatic cmd(input logic v, input logic w, input logic [31:0] a, input logic [31:0] d);
      bus.cmd_vld = v;
      bus.rw      = w;
      bus.addr    = a;
      bus.data_w  = d;
      step();
   endtask

   task automatic idle(input int n);
      for (int i = 0; i < n; i++) cmd(1'b0, 1'b0, 32'h0, 32'h0);
   endtask

   task automatic rand_cmd();
      logic [31:0] a;
      int sel;
      sel = int'($urandom_range(0, 11));
      if (sel <= 7)       a = ADDR_BASE + 32'(4 * $urandom_range(0, NUM_REGS - 1));
      else if (sel == 8)  a = ADDR_BASE + 32'(4 * NUM_REGS);
      else if (sel == 9)  a = ADDR_BASE + 32'(4 * $urandom_range(0, NUM_REGS - 1)) + 32'($urandom_range(1, 3));
      else if (sel == 10) a = ADDR_BASE - 32'(4 * $urandom_range(1, 8));
      else                a = $urandom;
      sts_in = $urandom;
      cmd($urandom_range(0, 3) != 0, 1'($urandom_range(0, 1)), a, $urandom);
   endtask

   // Async reset applied between edges; drops every read still in flight
   task automatic do_reset(input int n);
      rst_n = 1'b0;
      for (int i = 0; i < NUM_REGS; i++) m_regs[i] = 32'h0;
      m_err = 0;
      expq.delete();
      for (int i = 0; i < n; i++) rand_cmd();
      bus.cmd_vld = 1'b0;
      rst_n = 1'b1;
   endtask

   initial begin
      bus.cmd_vld = 1'b0;
      bus.rw      = 1'b0;
      bus.addr    = 32'h0;
      bus.data_w  = 32'h0;

      // 1: outputs quiet under reset, then ID read after release
      do_reset(6);
      cmd(1'b1, 1'b0, ADDR_BASE, 32'h0);
      idle(3);

      // 2: write then immediate read-back
      cmd(1'b1, 1'b1, ADDR_BASE + 32'd8, 32'hCAFE_F00D);
      cmd(1'b1, 1'b0, ADDR_BASE + 32'd8, 32'h0);
      chk("csr2_slice", CW'(csr_q[95:64]), CW'(32'hCAFE_F00D));
      idle(3);

      // 3: eight back-to-back reads
      for (int i = 2; i < 10; i++) cmd(1'b1, 1'b1, ADDR_BASE + 32'(4 * i), 32'h1000_0000 + 32'(i));
      for (int i = 2; i < 10; i++) cmd(1'b1, 1'b0, ADDR_BASE + 32'(4 * i), 32'h0);
      idle(3);

      // 4: illegal reads and writes
      cmd(1'b1, 1'b0, ADDR_BASE + 32'd2, 32'h0);
      cmd(1'b1, 1'b0, ADDR_BASE + 32'(4 * NUM_REGS + 4), 32'h0);
      cmd(1'b1, 1'b0, ADDR_BASE - 32'd4, 32'h0);
      idle(3);
`ifdef HOST_CSR_SLAVE_ERR_CNT_EN
      chk("err_cnt_3", CW'(err_cnt), CW'(16'd3));
`endif
      cmd(1'b1, 1'b1, ADDR_BASE + 32'd2, 32'hFFFF_FFFF);
      cmd(1'b1, 1'b1, ADDR_BASE + 32'(4 * NUM_REGS + 4), 32'hFFFF_FFFF);
      cmd(1'b1, 1'b1, ADDR_BASE - 32'd4, 32'hFFFF_FFFF);

      // 5: status CSR is read-only
      sts_in = 32'h0000_00A5;
      cmd(1'b1, 1'b1, ADDR_BASE + 32'd4, 32'h1234_5678);
      cmd(1'b1, 1'b0, ADDR_BASE + 32'd4, 32'h0);
      idle(3);

      // Randomized traffic
      for (int i = 0; i < 3000; i++) rand_cmd();
      idle(4);

      // 6: reset with a read in flight, then error counter clear
      cmd(1'b1, 1'b0, ADDR_BASE + 32'd8, 32'h0);
      do_reset(2);
      idle(5);
      cmd(1'b1, 1'b0, ADDR_BASE - 32'd8, 32'h0);
      cmd(1'b1, 1'b1, ADDR_BASE + 32'(4 * NUM_REGS), 32'h0);
      cmd(1'b1, 1'b0, ADDR_BASE + 32'(4 * NUM_REGS), 32'h0);
      idle(4);
      chk("err_cnt_end", CW'(err_cnt), CW'(16'h0));
      chk("expq_drained", CW'(expq.size()), CW'(0));

      $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
      $finish;
   end

endmodule
